// File: rtl/fp_norm_24.sv
// fp_norm_24 - post add/sub mantissa normalisation stage.
//
// Takes the raw {carry, sum} from the 24-bit mantissa adder/subtractor with
// the pre-aligned exponent and sign. It corrects an add carry-out with a 1-bit
// right shift, or a subtract borrow by negating and flipping the sign. It then
// left-shifts one bit per cycle until the hidden bit is set, and presents the
// normalised result to rounding/packing over a valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   upstream result available
//   in_ready   block can accept (high only while idle)
//   in_mant    sum from adder/subtractor
//   in_carry   add carry-out, or subtract borrow
//   in_is_sub  1 = in_mant came from the subtractor
//   in_exp     larger operand's biased exponent
//   in_sign    tentative result sign
//   out_valid  normalised result available
//   out_ready  downstream accepts
//   out_mant   normalised mantissa (hidden bit at MSB, 0 for zero/denormal)
//   out_exp    adjusted biased exponent
//   out_sign   final sign
//   out_zero   result is exactly zero
//   out_ovf    exponent overflow (infinity)
//   out_unf    denormal result, exponent clamped to 0
//   out_shift  number of left shifts performed
module fp_norm_24 #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_mant,
  input  logic              in_carry,
  input  logic              in_is_sub,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic              in_sign,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_sign,
  output logic              out_zero,
  output logic              out_ovf,
  output logic              out_unf,
  output logic [CNT_W-1:0]  out_shift
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_NORM = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        r_state;
  logic [MANT_W-1:0] r_mant;
  logic [EXP_W-1:0]  r_exp;
  logic              r_sign;
  logic              r_zero;
  logic              r_ovf;
  logic              r_unf;
  logic [CNT_W-1:0]  r_shift;

  logic [EXP_W-1:0]  w_exp_inc;
  logic              w_add_ovf;
  logic [MANT_W-1:0] w_neg;
  logic              w_add_carry;
  logic              w_sub_borrow;

  assign w_exp_inc    = in_exp + EXP_W'(1);
  // Incrementing into the all-ones exponent means the sum is infinity.
  assign w_add_ovf    = (w_exp_inc == {EXP_W{1'b1}});
  assign w_neg        = (~in_mant) + MANT_W'(1);
  assign w_add_carry  = ~in_is_sub & in_carry;
  assign w_sub_borrow = in_is_sub & in_carry;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_mant  = r_mant;
  assign out_exp   = r_exp;
  assign out_sign  = r_sign;
  assign out_zero  = r_zero;
  assign out_ovf   = r_ovf;
  assign out_unf   = r_unf;
  assign out_shift = r_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_mant  <= '0;
      r_exp   <= '0;
      r_sign  <= 1'b0;
      r_zero  <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      r_shift <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_shift <= '0;
            r_zero  <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_sign  <= in_sign;
            r_state <= S_NORM;
            if (w_add_carry) begin
              if (w_add_ovf) begin
                // Infinity needs no normalisation; present it immediately.
                r_ovf   <= 1'b1;
                r_mant  <= '0;
                r_exp   <= {EXP_W{1'b1}};
                r_state <= S_DONE;
              end else begin
                r_mant <= {1'b1, in_mant[MANT_W-1:1]};
                r_exp  <= w_exp_inc;
              end
            end else if (w_sub_borrow) begin
              // Borrow means b > a: take the magnitude and swap the sign.
              r_mant <= w_neg;
              r_exp  <= in_exp;
              r_sign <= ~in_sign;
            end else begin
              r_mant <= in_mant;
              r_exp  <= in_exp;
            end
          end
        end
        S_NORM: begin
          if (r_mant == '0) begin
            r_exp   <= '0;
            r_sign  <= 1'b0;
            r_zero  <= 1'b1;
            r_state <= S_DONE;
          end else if (r_mant[MANT_W-1]) begin
            r_state <= S_DONE;
          end else if (r_exp <= EXP_W'(1)) begin
            // Exponent exhausted: leave the mantissa as a denormal.
            r_exp   <= '0;
            r_unf   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_mant  <= {r_mant[MANT_W-2:0], 1'b0};
            r_exp   <= r_exp - EXP_W'(1);
            r_shift <= r_shift + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_norm_24.sv
module tb_fp_norm_24;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_mant;
  logic        in_carry;
  logic        in_is_sub;
  logic [7:0]  in_exp;
  logic        in_sign;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_mant;
  logic [7:0]  out_exp;
  logic        out_sign;
  logic        out_zero;
  logic        out_ovf;
  logic        out_unf;
  logic [4:0]  out_shift;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [23:0] mant;
    logic [7:0]  exp;
    logic        sign;
    logic        zero;
    logic        ovf;
    logic        unf;
    logic [4:0]  shift;
    int          lat;
  } res_t;

  fp_norm_24 dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mant(in_mant), .in_carry(in_carry), .in_is_sub(in_is_sub),
    .in_exp(in_exp), .in_sign(in_sign),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mant(out_mant), .out_exp(out_exp), .out_sign(out_sign),
    .out_zero(out_zero), .out_ovf(out_ovf), .out_unf(out_unf),
    .out_shift(out_shift)
  );

  always #5 clk = ~clk;

  // Reference: arithmetic view of the normalisation, not a cycle model.
  function automatic res_t model(input logic [23:0] m, input logic c, input logic s,
                                 input logic [7:0] e, input logic sg);
    res_t r;
    longint mv;
    int ee;
    int lz;
    int k;
    mv = m;
    ee = e;
    r.sign = sg; r.zero = 0; r.ovf = 0; r.unf = 0; r.shift = 0;
    if (!s && c) begin
      if (ee + 1 >= 255) begin
        r.mant = 0; r.exp = 8'd255; r.ovf = 1; r.lat = 0;
        return r;
      end
      mv = (mv + 64'h1000000) / 2;
      ee = ee + 1;
    end else if (s && c) begin
      mv = (64'h1000000 - mv) % 64'h1000000;
      r.sign = ~sg;
    end
    if (mv == 0) begin
      r.mant = 0; r.exp = 0; r.sign = 0; r.zero = 1; r.lat = 1;
      return r;
    end
    lz = 0;
    while (mv * (64'd1 << lz) < 64'h800000) lz++;
    if (lz == 0) k = 0;
    else if (ee <= 1) begin k = 0; r.unf = 1; end
    else if (ee - 1 >= lz) k = lz;
    else begin k = ee - 1; r.unf = 1; end
    r.mant  = 24'(mv * (64'd1 << k));
    r.exp   = r.unf ? 8'd0 : 8'(ee - k);
    r.shift = 5'(k);
    r.lat   = k + 1;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_outputs(input string tag, input res_t x);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, ".mant"}, 32'(out_mant), 32'(x.mant));
    chk({tag, ".exp"}, 32'(out_exp), 32'(x.exp));
    chk({tag, ".sign"}, 32'(out_sign), 32'(x.sign));
    chk({tag, ".zero"}, 32'(out_zero), 32'(x.zero));
    chk({tag, ".ovf"}, 32'(out_ovf), 32'(x.ovf));
    chk({tag, ".unf"}, 32'(out_unf), 32'(x.unf));
    chk({tag, ".shift"}, 32'(out_shift), 32'(x.shift));
  endtask

  // Offer one item at edge E0; returns the cycles after E0 until out_valid.
  task automatic send(input logic [23:0] m, input logic c, input logic s,
                      input logic [7:0] e, input logic sg, output int cyc);
    chk("pre.in_ready", 32'(in_ready), 32'd1);
    in_mant = m; in_carry = c; in_is_sub = s; in_exp = e; in_sign = sg;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic release_out(input string tag, input int hold, input res_t x);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk_outputs({tag, ".hold"}, x);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".drop_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".idle_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run(input string tag, input logic [23:0] m, input logic c, input logic s,
                     input logic [7:0] e, input logic sg, input int hold);
    res_t x;
    int cyc;
    x = model(m, c, s, e, sg);
    send(m, c, s, e, sg, cyc);
    chk({tag, ".latency"}, 32'(cyc), 32'(x.lat));
    chk_outputs(tag, x);
    release_out(tag, hold, x);
  endtask

  initial begin
    res_t x;
    int cyc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_mant = '0; in_carry = 1'b0; in_is_sub = 1'b0; in_exp = '0; in_sign = 1'b0;
    #12;
    chk("reset.valid", 32'(out_valid), 32'd0);
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    chk("reset.mant", 32'(out_mant), 32'd0);
    chk("reset.exp", 32'(out_exp), 32'd0);
    chk("reset.flags", 32'({out_sign, out_zero, out_ovf, out_unf}), 32'd0);
    chk("reset.shift", 32'(out_shift), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a 10-shift item.
    in_mant = 24'h002000; in_carry = 0; in_is_sub = 0; in_exp = 8'h80; in_sign = 1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); rst = 1'b1; #1;
    chk("midrst.valid", 32'(out_valid), 32'd0);
    chk("midrst.in_ready", 32'(in_ready), 32'd1);
    chk("midrst.mant", 32'(out_mant), 32'd0);
    chk("midrst.exp", 32'(out_exp), 32'd0);
    chk("midrst.shift", 32'(out_shift), 32'd0);
    chk("midrst.flags", 32'({out_sign, out_zero, out_ovf, out_unf}), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Directed items with hand-derived expectations.
    send(24'h000001, 1, 0, 8'h80, 0, cyc);
    chk("addc.latency", 32'(cyc), 32'd1);
    chk("addc.mant", 32'(out_mant), 32'h800000);
    chk("addc.exp", 32'(out_exp), 32'h81);
    chk("addc.shift", 32'(out_shift), 32'd0);
    x.mant = 24'h800000; x.exp = 8'h81; x.sign = 0; x.zero = 0; x.ovf = 0; x.unf = 0;
    x.shift = 0; x.lat = 1;
    release_out("addc", 0, x);

    send(24'h000C00, 0, 1, 8'h90, 0, cyc);
    chk("sub12.latency", 32'(cyc), 32'd13);
    chk("sub12.mant", 32'(out_mant), 32'hC00000);
    chk("sub12.exp", 32'(out_exp), 32'h84);
    chk("sub12.shift", 32'(out_shift), 32'd12);
    x.mant = 24'hC00000; x.exp = 8'h84; x.shift = 12; x.lat = 13;
    release_out("sub12", 1, x);

    send(24'hFFFFFF, 1, 1, 8'h40, 0, cyc);
    chk("borrow.latency", 32'(cyc), 32'd24);
    chk("borrow.mant", 32'(out_mant), 32'h800000);
    chk("borrow.exp", 32'(out_exp), 32'h29);
    chk("borrow.sign", 32'(out_sign), 32'd1);
    chk("borrow.shift", 32'(out_shift), 32'd23);
    x.mant = 24'h800000; x.exp = 8'h29; x.sign = 1; x.shift = 23; x.lat = 24;
    release_out("borrow", 0, x);

    send(24'h000000, 0, 0, 8'h50, 1, cyc);
    chk("zero.latency", 32'(cyc), 32'd1);
    chk("zero.flag", 32'(out_zero), 32'd1);
    chk("zero.exp", 32'(out_exp), 32'd0);
    chk("zero.sign", 32'(out_sign), 32'd0);
    x.mant = 0; x.exp = 0; x.sign = 0; x.zero = 1; x.shift = 0; x.lat = 1;
    release_out("zero", 0, x);

    send(24'h000100, 0, 0, 8'h03, 0, cyc);
    chk("unf.latency", 32'(cyc), 32'd3);
    chk("unf.flag", 32'(out_unf), 32'd1);
    chk("unf.exp", 32'(out_exp), 32'd0);
    chk("unf.mant", 32'(out_mant), 32'h000400);
    chk("unf.shift", 32'(out_shift), 32'd2);
    x.mant = 24'h000400; x.exp = 0; x.zero = 0; x.unf = 1; x.shift = 2; x.lat = 3;
    release_out("unf", 0, x);

    send(24'h123456, 1, 0, 8'hFE, 1, cyc);
    chk("ovf.latency", 32'(cyc), 32'd0);
    chk("ovf.flag", 32'(out_ovf), 32'd1);
    chk("ovf.exp", 32'(out_exp), 32'hFF);
    chk("ovf.mant", 32'(out_mant), 32'd0);
    x.mant = 0; x.exp = 8'hFF; x.sign = 1; x.zero = 0; x.ovf = 1; x.unf = 0;
    x.shift = 0; x.lat = 0;
    release_out("ovf", 5, x);

    // Model-checked corners and random items.
    run("m.exp1", 24'h400000, 0, 0, 8'h01, 0, 0);
    run("m.exp0n", 24'h800001, 0, 0, 8'h00, 1, 0);
    run("m.subz", 24'h000000, 1, 1, 8'h22, 1, 1);
    run("m.add253", 24'hFFFFFF, 1, 0, 8'hFD, 0, 0);
    for (int i = 0; i < 40; i++) begin
      logic [23:0] m;
      m = 24'($urandom) >> $urandom_range(0, 24);
      run("rand", m, 1'($urandom), 1'($urandom), 8'($urandom_range(0, 254)),
          1'($urandom), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/fp_norm_24.md
Name: fp_norm_24

Overview:
- Normalisation stage directly downstream of the 24-bit mantissa add/sub units in the floating-point adder datapath.
- Consumes the raw {carry_out, sum} result together with the pre-aligned exponent and sign.
- Fixes add carry-out with a 1-bit right shift; fixes a subtract borrow by negating and flipping the sign.
- Iteratively left-shifts until the hidden bit (bit 23) is set, adjusting the exponent, and hands a normalised mantissa/exponent to rounding/packing through a valid/ready handshake.

Parameters:
MANT_W, 24, mantissa width including hidden bit (block verified at 24 only)
EXP_W, 8, biased exponent width
CNT_W, 5, width of shift-count output (ceil(log2(MANT_W))+0)

Ports:
clk  input  1  rising-edge clock; only clock in the block
rst  input  1  asynchronous, active-high reset
in_valid  input  1  upstream result available
in_ready  output  1  block can accept; high only in IDLE
in_mant  input  24  sum from adder/subtractor
in_carry  input  1  carry_out from adder (add) or borrow from subtractor (sub)
in_is_sub  input  1  1 = in_mant came from the subtractor
in_exp  input  8  larger operand's biased exponent
in_sign  input  1  tentative result sign
out_valid  output  1  normalised result available
out_ready  input  1  downstream accepts
out_mant  output  24  normalised mantissa, bit 23 = hidden bit (0 for zero/denormal)
out_exp  output  8  adjusted biased exponent
out_sign  output  1  final sign
out_zero  output  1  result is exactly zero
out_ovf  output  1  exponent overflow (result is infinity)
out_unf  output  1  result denormal (exponent clamped to 0)
out_shift  output  5  number of left shifts performed (0..23)

Behaviour:
- Reset (async, rst=1): state IDLE; all internal regs and every output register cleared to 0 (out_valid=0, out_mant=0, out_exp=0, out_sign=0, flags=0, out_shift=0). in_ready=1 during and after reset (decoded from IDLE). Reset mid-operation aborts the in-flight item with no output.
- FSM states: IDLE, NORM, DONE.
- IDLE: in_ready=1. On in_valid&in_ready at edge E0, capture the operand with pre-fix applied, shift count cleared, and go to NORM.
  - Add, carry=1: mant = {1, in_mant[23:1]}, exp = in_exp+1. If in_exp+1 == 255, set ovf, mant=0, exp=255, and go directly to DONE.
  - Sub, carry=1 (borrow): mant = (~in_mant)+1 mod 2^24, sign = ~in_sign.
  - Otherwise: mant and exp captured unchanged.
- NORM: evaluated each cycle in priority order.
  1. mant==0: exp=0, sign=0, zero=1; go to DONE.
  2. mant[23]==1: go to DONE.
  3. exp<=1: exp=0, unf=1, mant kept as-is; go to DONE.
  4. Otherwise: mant<<=1 (zero fill), exp-=1, shift+=1; stay in NORM.
- DONE: out_valid=1 and outputs held stable. On out_ready, go to IDLE at the next edge and drop out_valid. No new input is accepted in DONE (in_ready=0), so there is no simultaneous in/out transfer.
- Latency: with k left shifts, out_valid rises after edge E0+k+1. Already-normalised or add-carry input gives out_valid after E0+1. Zero is detected at E0+1. Add overflow gives out_valid after E0 (direct to DONE). Maximum k=23.
- Throughput: one item per (k+3) cycles minimum when out_ready is held high.
- Arithmetic: exponent is unsigned 8-bit. Add increment and shift decrement never wrap because of the ovf and unf guards.
- Contract: in_exp=255 (inf/NaN) is not sent to this block; those cases are bypassed upstream.
- out_valid is not deasserted while out_ready=0; outputs do not change while out_valid=1.

Test Plan:
1. Reset: assert rst mid-NORM (during a 10-shift item) -> same cycle: out_valid=0, in_ready=1, all outputs 0. After release, the next item is processed normally.
2. Add carry: mant=0x000001, carry=1, is_sub=0, exp=0x80 -> out_mant=0x800000, out_exp=0x81, out_shift=0, out_valid after E0+1.
3. Sub needing shifts: mant=0x000C00, carry=0, is_sub=1, exp=0x90 -> 12 shifts, out_mant=0xC00000, out_exp=0x84, out_shift=12, out_valid after E0+13.
4. Borrow: mant=0xFFFFFF, carry=1, is_sub=1, sign=0, exp=0x40 -> negated to 0x000001. 23 shifts -> out_mant=0x800000, out_exp=0x29, out_sign=1.
5. Zero and underflow:
   - mant=0, exp=0x50 -> out_zero=1, out_exp=0, out_sign=0.
   - mant=0x000100, exp=3 -> 2 shifts, then out_unf=1, out_exp=0, out_mant=0x000400.
6. Overflow and backpressure: add carry with exp=0xFE -> out_ovf=1, out_exp=0xFF, out_mant=0. Hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0. Raise out_ready -> back to IDLE next edge.
